dual_issue_scheduler: RTL and testbench
=======================================

DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
- REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
- REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
- REQ-003 SHALL have port instruction0  in  32  oldest fetch-buffer slot; 32'h0 = empty.
- REQ-004 SHALL have port instruction1  in  32  next fetch-buffer slot; 32'h0 = empty.
- REQ-005 SHALL have port nothing_filled  in  1  fetch buffer empty.
- REQ-006 SHALL have port ex_busy  in  1  execute stage cannot accept this cycle.
- REQ-007 SHALL have port flush  in  1  redirect; discard all in-flight issue state.
- REQ-008 SHALL have port freeze1  out  1  hold fetch buffer (any stall), combinational.
- REQ-009 SHALL have port freeze2  out  1  stall caused by ex_busy only, combinational.
- REQ-010 SHALL have port dependency_on_ins2  out  1  single issue this cycle; buffer slides by 1, combinational.
- REQ-011 SHALL have ports issue0_valid/issue1_valid  out  1 each  registered issue-slot valids.
- REQ-012 SHALL have ports issue0_instr/issue1_instr  out  32 each  registered issued instructions.

Function
- REQ-013 SHALL decode RV32I fields: rd[11:7], rs1[19:15], rs2[24:20]; opcode[6:0] classes LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
- REQ-014 SHALL treat rd=x0 as never producing a hazard; rs2 considered only for R-type, STORE, BRANCH.
- REQ-015 SHALL implement FSM states EMPTY, RUN, LOAD_STALL, EX_STALL.
- REQ-016 Priority each cycle: flush > ex_busy > load-use > empty buffer > pair rules.
- REQ-017 flush: next state EMPTY, issue valids 0 next cycle, pending-load cleared, freeze1/freeze2/dependency_on_ins2 = 0.
- REQ-018 ex_busy=1: freeze1=1, freeze2=1, issue registers hold their values, state EX_STALL; leave EX_STALL the first cycle ex_busy=0.
- REQ-019 Load-use: if a LOAD issued last cycle (pending_load_valid) and instruction0 reads its rd, freeze1=1, freeze2=0, issue valids 0, state LOAD_STALL for exactly 1 cycle, pending_load_valid then cleared.
- REQ-020 nothing_filled=1 or instruction0=0: no issue, all freeze/dependency outputs 0, state EMPTY.
- REQ-021 Single-issue (dependency_on_ins2=1, issue0 only) when any: instruction1 reads instruction0 rd (RAW); both are LOAD/STORE (one memory port); instruction0 is BRANCH/JAL/JALR; instruction1 = 0.
- REQ-022 Otherwise dual issue: issue0/issue1 valid next cycle with instruction0/instruction1, dependency_on_ins2=0.
- REQ-023 Load-use check in REQ-019 SHALL also cover instruction1 on dual issue: a hit on instruction1 only forces single issue (REQ-021), not a stall.
- REQ-024 pending_load_rd SHALL record rd of the issued LOAD (slot0 or slot1, at most one per REQ-021); cleared on any cycle issuing no LOAD.
- REQ-025 Issue latency: 1 cycle from input sampling to issueN_valid.

Reset
- REQ-026 rst_n=0 SHALL immediately force state EMPTY, issue valids 0, issue instrs 32'h0, pending load cleared.
- REQ-027 Combinational outputs SHALL read 0 while rst_n=0; first issue possible on the first rising edge after deassertion.

Configuration
- REQ-028 Macro SCHED_PERF_CNT_EN defined: adds outputs perf_dual[31:0], perf_single[31:0], perf_stall[31:0] counting dual-issue, single-issue, and freeze1 cycles; wrap modulo 2^32; reset to 0; flush does not clear.
- REQ-029 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
- REQ-030 addi x1,x0,1 / addi x2,x0,2 -> dependency_on_ins2=0, next cycle both issue valids 1 with same encodings.
- REQ-031 addi x1,x0,1 / add x3,x1,x1 -> dependency_on_ins2=1, next cycle issue0_valid=1, issue1_valid=0.
- REQ-032 issue lw x5,0(x0); next instruction0 add x6,x5,x0 -> freeze1=1, freeze2=0 one cycle, no issue, then add issues.
- REQ-033 ex_busy held 3 cycles mid-stream -> freeze1=freeze2=1 for 3 cycles, issue regs unchanged, resumes cycle 4.
- REQ-034 flush coincident with ex_busy and load-use -> freeze outputs 0, valids 0 next cycle, state EMPTY.
- REQ-035 rst_n pulsed low mid-dual-issue -> valids 0 asynchronously; with SCHED_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Dual-issue in-order scheduler for an RV32I pipeline.
// Picks 0, 1 or 2 instructions from the head of the fetch buffer each cycle,
// detecting load-use, RAW-in-pair, memory-port and control-flow hazards.
// Optional build macro SCHED_PERF_CNT_EN adds dual/single/stall cycle counters.
module dual_issue_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        nothing_filled,
    input  logic        ex_busy,
    input  logic        flush,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic        issue1_valid,
    output logic [31:0] issue0_instr,
    output logic [31:0] issue1_instr
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] perf_dual,
    output logic [31:0] perf_single,
    output logic [31:0] perf_stall
`endif
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [1:0] {EMPTY, RUN, LOAD_STALL, EX_STALL} state_t;

    state_t      r_state;
    logic        r_v0, r_v1;
    logic [31:0] r_i0, r_i1;
    logic        r_pend_v;
    logic [4:0]  r_pend_rd;

    // STORE and BRANCH carry immediate bits in [11:7]; they write no register.
    function automatic logic f_writes(input logic [31:0] i);
        return (i[11:7] != 5'd0) && (i[6:0] != OP_STORE) && (i[6:0] != OP_BRANCH);
    endfunction

    function automatic logic f_uses_rs2(input logic [31:0] i);
        return (i[6:0] == OP_RTYPE) || (i[6:0] == OP_STORE) || (i[6:0] == OP_BRANCH);
    endfunction

    // rs1 is treated as always read (conservative); x0 never creates a hazard.
    function automatic logic f_reads(input logic [31:0] i, input logic [4:0] r);
        return (r != 5'd0) && ((i[19:15] == r) || (f_uses_rs2(i) && (i[24:20] == r)));
    endfunction

    function automatic logic f_mem(input logic [31:0] i);
        return (i[6:0] == OP_LOAD) || (i[6:0] == OP_STORE);
    endfunction

    function automatic logic f_ctrl(input logic [31:0] i);
        return (i[6:0] == OP_BRANCH) || (i[6:0] == OP_JAL) || (i[6:0] == OP_JALR);
    endfunction

    logic w_pend_live, w_hit0, w_hit1, w_empty, w_raw, w_single;
    logic w_issue, w_dual, w_sgl, w_ld0, w_ld1;

    // Hazard classification and issue decision, in priority order.
    always_comb begin
        w_pend_live = r_pend_v && (r_state != LOAD_STALL);
        w_hit0      = w_pend_live && f_reads(instruction0, r_pend_rd);
        w_hit1      = w_pend_live && f_reads(instruction1, r_pend_rd);
        w_empty     = nothing_filled || (instruction0 == 32'h0);
        w_raw       = f_writes(instruction0) && f_reads(instruction1, instruction0[11:7]);
        w_single    = w_raw || (f_mem(instruction0) && f_mem(instruction1)) ||
                      f_ctrl(instruction0) || (instruction1 == 32'h0) || w_hit1;
        w_issue     = !flush && !ex_busy && !w_hit0 && !w_empty;
        w_dual      = w_issue && !w_single;
        w_sgl       = w_issue && w_single;
        w_ld0       = (instruction0[6:0] == OP_LOAD) && (instruction0[11:7] != 5'd0);
        w_ld1       = w_dual && (instruction1[6:0] == OP_LOAD) && (instruction1[11:7] != 5'd0);
    end

    assign freeze1            = rst_n && !flush && (ex_busy || w_hit0);
    assign freeze2            = rst_n && !flush && ex_busy;
    assign dependency_on_ins2 = rst_n && w_sgl;
    assign issue0_valid       = r_v0;
    assign issue1_valid       = r_v1;
    assign issue0_instr       = r_i0;
    assign issue1_instr       = r_i1;

    // Scheduler FSM with registered issue slots and pending-load tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_i0      <= 32'h0;
            r_i1      <= 32'h0;
            r_pend_v  <= 1'b0;
            r_pend_rd <= 5'd0;
        end else if (flush) begin
            r_state  <= EMPTY;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_pend_v <= 1'b0;
        end else if (ex_busy) begin
            // Issue slots hold; nothing new issues, so no load is pending.
            r_state  <= EX_STALL;
            r_pend_v <= 1'b0;
        end else if (w_hit0) begin
            r_state  <= LOAD_STALL;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_pend_v <= 1'b0;
        end else if (w_empty) begin
            r_state  <= EMPTY;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_pend_v <= 1'b0;
        end else begin
            r_state   <= RUN;
            r_v0      <= 1'b1;
            r_i0      <= instruction0;
            r_v1      <= w_dual;
            r_i1      <= w_dual ? instruction1 : 32'h0;
            r_pend_v  <= w_ld0 || w_ld1;
            r_pend_rd <= w_ld0 ? instruction0[11:7] : (w_ld1 ? instruction1[11:7] : 5'd0);
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_perf_dual, r_perf_single, r_perf_stall;

    // Free-running cycle counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_dual   <= 32'h0;
            r_perf_single <= 32'h0;
            r_perf_stall  <= 32'h0;
        end else begin
            if (w_dual)  r_perf_dual   <= r_perf_dual + 32'd1;
            if (w_sgl)   r_perf_single <= r_perf_single + 32'd1;
            if (freeze1) r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_dual   = r_perf_dual;
    assign perf_single = r_perf_single;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Randomized + directed bench for dual_issue_scheduler against a rule-level model.
module tb_dual_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction0, instruction1;
    logic        nothing_filled, ex_busy, flush;
    logic        freeze1, freeze2, dependency_on_ins2;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_dual, perf_single, perf_stall;
`endif

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .instruction0(instruction0), .instruction1(instruction1),
        .nothing_filled(nothing_filled), .ex_busy(ex_busy), .flush(flush),
        .freeze1(freeze1), .freeze2(freeze2), .dependency_on_ins2(dependency_on_ins2),
        .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
        .issue0_instr(issue0_instr), .issue1_instr(issue1_instr)
`ifdef SCHED_PERF_CNT_EN
        , .perf_dual(perf_dual), .perf_single(perf_single), .perf_stall(perf_stall)
`endif
    );

    localparam logic [31:0] ADDI1 = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] ADDI2 = 32'h00200113; // addi x2,x0,2
    localparam logic [31:0] ADD3  = 32'h001081B3; // add  x3,x1,x1
    localparam logic [31:0] LW5   = 32'h00002283; // lw   x5,0(x0)
    localparam logic [31:0] ADD6  = 32'h00028333; // add  x6,x5,x0

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_v0, m_v1;
    logic [31:0] m_i0, m_i1;
    bit          m_pv;
    bit   [4:0]  m_prd;
    int unsigned m_pd, m_ps, m_pst;

    function automatic bit is_op(input logic [31:0] i, input int op);
        return int'(i[6:0]) == op;
    endfunction

    // destination register, or 0 when the instruction writes nothing
    function automatic int dest(input logic [31:0] i);
        if (is_op(i, 'h23) || is_op(i, 'h63)) return 0;
        return int'(i[11:7]);
    endfunction

    function automatic bit reads(input logic [31:0] i, input int r);
        if (r == 0) return 0;
        if (int'(i[19:15]) == r) return 1;
        if ((is_op(i, 'h33) || is_op(i, 'h23) || is_op(i, 'h63)) && int'(i[24:20]) == r) return 1;
        return 0;
    endfunction

    function automatic bit memop(input logic [31:0] i);
        return is_op(i, 'h03) || is_op(i, 'h23);
    endfunction

    function automatic bit ctlop(input logic [31:0] i);
        return is_op(i, 'h63) || is_op(i, 'h6F) || is_op(i, 'h67);
    endfunction

    task automatic model_reset();
        m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0; m_pv = 0; m_prd = 0;
        m_pd = 0; m_ps = 0; m_pst = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_v0"}, issue0_valid, m_v0);
        chk({tag, "_v1"}, issue1_valid, m_v1);
        if (m_v0) chk({tag, "_i0"}, issue0_instr, m_i0);
        if (m_v1) chk({tag, "_i1"}, issue1_instr, m_i1);
`ifdef SCHED_PERF_CNT_EN
        chk({tag, "_pdual"}, perf_dual, m_pd);
        chk({tag, "_psgl"}, perf_single, m_ps);
        chk({tag, "_pstall"}, perf_stall, m_pst);
`endif
    endtask

    // One clock: drive, check combinational outputs, clock, check issue regs.
    // kind: 0 flush, 1 busy, 2 load-use, 3 empty, 4 single, 5 dual
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input bit nf, input bit eb, input bit fl);
        int kind;
        bit hit0, hit1, e_f1;
        instruction0 = a; instruction1 = b;
        nothing_filled = nf; ex_busy = eb; flush = fl;
        #1;
        hit0 = m_pv && reads(a, int'(m_prd));
        hit1 = m_pv && reads(b, int'(m_prd));
        if (fl) kind = 0;
        else if (eb) kind = 1;
        else if (hit0) kind = 2;
        else if (nf || a == 0) kind = 3;
        else if ((dest(a) != 0 && reads(b, dest(a))) || (memop(a) && memop(b)) ||
                 ctlop(a) || b == 0 || hit1) kind = 4;
        else kind = 5;
        e_f1 = (kind == 1 || kind == 2);
        chk("freeze1", freeze1, e_f1);
        chk("freeze2", freeze2, kind == 1);
        chk("dep_ins2", dependency_on_ins2, kind == 4);
        @(posedge clk);
        #1;
        if (e_f1) m_pst++;
        case (kind)
            1: m_pv = 0;
            4, 5: begin
                m_v0 = 1; m_i0 = a;
                m_v1 = (kind == 5); if (kind == 5) m_i1 = b;
                m_pv = 0;
                if (is_op(a, 'h03) && a[11:7] != 0) begin m_pv = 1; m_prd = a[11:7]; end
                else if (kind == 5 && is_op(b, 'h03) && b[11:7] != 0) begin m_pv = 1; m_prd = b[11:7]; end
                if (kind == 5) m_pd++; else m_ps++;
            end
            default: begin m_v0 = 0; m_v1 = 0; m_pv = 0; end
        endcase
        chk_regs("regs");
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [6:0] ops [8];
        logic [6:0] op;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
        ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h67; ops[7] = 7'h37;
        if ($urandom_range(0, 9) == 0) return 32'h0;
        op = ops[$urandom_range(0, 7)];
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        rst_n = 0; instruction0 = ADDI1; instruction1 = ADDI2;
        nothing_filled = 0; ex_busy = 1; flush = 0;
        model_reset();
        #2;
        chk("rst_f1", freeze1, 0);
        chk("rst_f2", freeze2, 0);
        chk("rst_dep", dependency_on_ins2, 0);
        chk("rst_i0", issue0_instr, 32'h0);
        chk("rst_i1", issue1_instr, 32'h0);
        chk_regs("rst");
        ex_busy = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        #2;

        // independent pair issues together
        step(ADDI1, ADDI2, 0, 0, 0);
        chk("pair_v1", issue1_valid, 1);
        chk("pair_i1", issue1_instr, ADDI2);
        // RAW within the pair forces single issue
        step(ADDI1, ADD3, 0, 0, 0);
        chk("raw_v1", issue1_valid, 0);
        // load-use: one bubble, then the consumer goes
        step(LW5, 32'h0, 0, 0, 0);
        step(ADD6, ADDI2, 0, 0, 0);
        chk("lu_v0", issue0_valid, 0);
        step(ADD6, ADDI2, 0, 0, 0);
        chk("lu_go", issue0_instr, ADD6);
        // ex_busy for 3 cycles holds the issue registers
        step(ADDI1, ADDI2, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(ADD3, ADD6, 0, 1, 0);
        chk("busy_i0", issue0_instr, ADDI1);
        chk("busy_i1", issue1_instr, ADDI2);
        step(ADD3, ADD6, 0, 0, 0);
        // flush beats ex_busy and load-use
        step(LW5, 32'h0, 0, 0, 0);
        step(ADD6, ADDI2, 0, 1, 1);
        chk("fl_v0", issue0_valid, 0);
        // async reset in the middle of dual issue
        step(ADDI1, ADDI2, 0, 0, 0);
        #3; rst_n = 0; ex_busy = 1; #1;
        model_reset();
        chk("arst_f1", freeze1, 0);
        chk_regs("arst");
        #2; ex_busy = 0; rst_n = 1;
        @(negedge clk);

        for (int n = 0; n < 3000; n++)
            step(rnd_ins(), rnd_ins(), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
